// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared encodings for the integer execution unit.
//                funct3 encodings for ALU ops and conditional branches,
//                the position of the alt bit inside the 4-bit op field,
//                and small field-extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    // The op field is {alt, funct3}; alt is funct7[5] for ALU ops.
    localparam int OP_W    = 4;
    localparam int ALT_BIT = 3;

    // ALU funct3 encodings
    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // Branch funct3 encodings (2 and 3 are unused and never taken)
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    function automatic logic [2:0] op_funct3(input logic [OP_W-1:0] op);
        return op[2:0];
    endfunction

    function automatic logic op_alt(input logic [OP_W-1:0] op);
        return op[ALT_BIT];
    endfunction

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : exec_alu_core
//  Description : Purely combinational integer datapath. Computes the ALU
//                result or, for conditional branches, the link value
//                (pc + 4), the branch outcome, the misprediction flag and
//                the corrected next PC.
//  Ports       : src1, src2     - operands
//                pc, target     - op PC and predicted/computed target
//                op             - {alt, funct3}
//                is_branch,pred - branch op flag and predicted-taken bit
//                result         - ALU result, or pc + 4 for branches
//                taken          - branch outcome (0 for non-branch ops)
//                mispredict     - taken XOR pred (0 for non-branch ops)
//                redirect       - correct next PC (0 for non-branch ops)
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_alu_core
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    input  logic [OP_W-1:0] op,
    input  logic            is_branch,
    input  logic            pred,
    output logic [XLEN-1:0] result,
    output logic            taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect
);

    localparam int SHW = $clog2(XLEN);

    logic [2:0]      funct3;
    logic            alt;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] pc_plus4;
    logic            eq;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [XLEN-1:0] alu_res;
    logic            br_taken;

    assign funct3      = op_funct3(op);
    assign alt         = op_alt(op);
    assign shamt       = src2[SHW-1:0];
    assign pc_plus4    = pc + XLEN'(4);
    assign eq          = (src1 == src2);
    assign lt_signed   = ($signed(src1) < $signed(src2));
    assign lt_unsigned = (src1 < src2);

    always_comb begin
        alu_res = '0;
        case (funct3)
            F3_ADD_SUB: alu_res = alt ? (src1 - src2) : (src1 + src2);
            F3_SLL:     alu_res = src1 << shamt;
            F3_SLT:     alu_res = {{(XLEN-1){1'b0}}, lt_signed};
            F3_SLTU:    alu_res = {{(XLEN-1){1'b0}}, lt_unsigned};
            F3_XOR:     alu_res = src1 ^ src2;
            F3_SRL_SRA: alu_res = alt ? $unsigned($signed(src1) >>> shamt)
                                      : (src1 >> shamt);
            F3_OR:      alu_res = src1 | src2;
            F3_AND:     alu_res = src1 & src2;
            default:    alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = eq;
            F3_BNE:  br_taken = ~eq;
            F3_BLT:  br_taken = lt_signed;
            F3_BGE:  br_taken = ~lt_signed;
            F3_BLTU: br_taken = lt_unsigned;
            F3_BGEU: br_taken = ~lt_unsigned;
            default: br_taken = 1'b0;
        endcase
    end

    // Branches write pc + 4 (link value); the branch-only outputs are forced
    // to zero for ALU ops so the CDB never sees stale redirect info.
    always_comb begin
        result     = alu_res;
        taken      = 1'b0;
        mispredict = 1'b0;
        redirect   = '0;
        if (is_branch) begin
            result     = pc_plus4;
            taken      = br_taken;
            mispredict = br_taken ^ pred;
            redirect   = br_taken ? target : pc_plus4;
        end
    end

endmodule : exec_alu_core
`default_nettype wire

// File: rtl/exec_int_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_int_unit
//  Description : Integer execution unit. Wraps the combinational datapath in
//                a STAGES-deep (1..3) valid/ready pipeline that broadcasts
//                results onto the CDB. All slots shift together when the
//                output is consumed or empty; flush kills every in-flight
//                op and the op offered in the same cycle.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                flush               - kill in-flight and offered ops
//                in_valid / in_ready - issue handshake
//                in_src1, in_src2    - operands
//                in_pc, in_target    - op PC and branch target
//                in_op               - {alt, funct3}
//                in_is_branch,in_pred- conditional branch flag, predicted taken
//                in_dst_valid/_tag   - destination register write and tag
//                out_valid/out_ready - CDB broadcast handshake
//                out_result          - ALU result or pc + 4 for branches
//                out_dst_valid/_tag  - destination info of the broadcast op
//                out_mispredict      - branch mispredicted
//                out_redirect        - correct next PC for branches
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_int_unit
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 4,
    parameter int STAGES = 1    // legal range 1..3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_target,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_is_branch,
    input  logic             in_pred,
    input  logic             in_dst_valid,
    input  logic [TAG_W-1:0] in_dst_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_dst_valid,
    output logic [TAG_W-1:0] out_dst_tag,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect
);

    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] alu_redirect;
    logic            alu_mispredict;
    // The outcome is already folded into mispredict/redirect; it is not
    // carried down the pipeline.
    logic            alu_taken_unused;

    logic            advance;
    logic            accept;

    exec_alu_core #(
        .XLEN(XLEN)
    ) u_alu_core (
        .src1       (in_src1),
        .src2       (in_src2),
        .pc         (in_pc),
        .target     (in_target),
        .op         (in_op),
        .is_branch  (in_is_branch),
        .pred       (in_pred),
        .result     (alu_result),
        .taken      (alu_taken_unused),
        .mispredict (alu_mispredict),
        .redirect   (alu_redirect)
    );

    // The whole pipe moves as one shift register: it may move whenever the
    // tail slot is empty or being consumed by the CDB.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance & ~flush & ~rst;
    assign accept   = in_valid & in_ready;

    genvar s;
    for (s = 0; s < STAGES; s = s + 1) begin : g_stage
        logic             valid;
        logic [XLEN-1:0]  result;
        logic             mispredict;
        logic [XLEN-1:0]  redirect;
        logic             dst_valid;
        logic [TAG_W-1:0] dst_tag;

        if (s == 0) begin : g_head
            // Slot 0 captures the datapath output; with no accept it takes a
            // bubble (payload left as-is, it is qualified by valid).
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid      <= 1'b0;
                    result     <= '0;
                    mispredict <= 1'b0;
                    redirect   <= '0;
                    dst_valid  <= 1'b0;
                    dst_tag    <= '0;
                end else if (flush) begin
                    valid <= 1'b0;
                end else if (advance) begin
                    valid <= accept;
                    if (accept) begin
                        result     <= alu_result;
                        mispredict <= alu_mispredict;
                        redirect   <= alu_redirect;
                        dst_valid  <= in_dst_valid;
                        dst_tag    <= in_dst_tag;
                    end
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid      <= 1'b0;
                    result     <= '0;
                    mispredict <= 1'b0;
                    redirect   <= '0;
                    dst_valid  <= 1'b0;
                    dst_tag    <= '0;
                end else if (flush) begin
                    valid <= 1'b0;
                end else if (advance) begin
                    valid      <= g_stage[s-1].valid;
                    result     <= g_stage[s-1].result;
                    mispredict <= g_stage[s-1].mispredict;
                    redirect   <= g_stage[s-1].redirect;
                    dst_valid  <= g_stage[s-1].dst_valid;
                    dst_tag    <= g_stage[s-1].dst_tag;
                end
            end
        end
    end

    // Outputs come straight from the tail slot's registers.
    assign out_valid      = g_stage[STAGES-1].valid;
    assign out_result     = g_stage[STAGES-1].result;
    assign out_mispredict = g_stage[STAGES-1].mispredict;
    assign out_redirect   = g_stage[STAGES-1].redirect;
    assign out_dst_valid  = g_stage[STAGES-1].dst_valid;
    assign out_dst_tag    = g_stage[STAGES-1].dst_tag;

endmodule : exec_int_unit
`default_nettype wire

// File: tb/tb_exec_int_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_int_unit
//  Description : Scoreboard bench for exec_int_unit (STAGES = 2). The driver
//                pushes the reference-model result of every accepted op into
//                a queue; an independent monitor pops and compares on every
//                CDB broadcast, checks latency and output stability under
//                backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_int_unit;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 4;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  in_src1 = '0, in_src2 = '0, in_pc = '0, in_target = '0;
    logic [3:0]       in_op = '0;
    logic             in_is_branch = 1'b0, in_pred = 1'b0, in_dst_valid = 1'b0;
    logic [TAG_W-1:0] in_dst_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result, out_redirect;
    logic             out_dst_valid, out_mispredict;
    logic [TAG_W-1:0] out_dst_tag;

    exec_int_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc), .in_target(in_target),
        .in_op(in_op), .in_is_branch(in_is_branch), .in_pred(in_pred),
        .in_dst_valid(in_dst_valid), .in_dst_tag(in_dst_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dst_valid(out_dst_valid), .out_dst_tag(out_dst_tag),
        .out_mispredict(out_mispredict), .out_redirect(out_redirect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src1, src2, pc, target;
        logic [3:0]  op;
        logic        isb, pred, dv;
        logic [3:0]  tag;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic        misp;
        logic [31:0] redir;
        logic        dv;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   lat_mode  = 1'b0;
    bit   head_seen = 1'b0;
    op_t  idle_op;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: instruction semantics with plain integer arithmetic.
    function automatic exp_t model(input op_t o);
        exp_t        e;
        int          sa, sb, sh;
        int unsigned ua, ub;
        bit          t;
        sa = int'(o.src1);  sb = int'(o.src2);
        ua = o.src1;        ub = o.src2;
        sh = int'(o.src2 & 32'd31);
        e.res = '0; e.misp = 1'b0; e.redir = '0;
        e.dv = o.dv; e.tag = o.tag; e.acc = 0; e.lat = 1'b0;
        if (o.isb) begin
            case (o.op[2:0])
                3'd0:    t = (ua == ub);
                3'd1:    t = (ua != ub);
                3'd4:    t = (sa <  sb);
                3'd5:    t = (sa >= sb);
                3'd6:    t = (ua <  ub);
                3'd7:    t = (ua >= ub);
                default: t = 1'b0;
            endcase
            e.res   = o.pc + 32'd4;
            e.misp  = (t != o.pred);
            e.redir = t ? o.target : o.pc + 32'd4;
        end else begin
            case (o.op[2:0])
                3'd0:    e.res = o.op[3] ? ua - ub : ua + ub;
                3'd1:    e.res = ua << sh;
                3'd2:    e.res = (sa < sb) ? 32'd1 : 32'd0;
                3'd3:    e.res = (ua < ub) ? 32'd1 : 32'd0;
                3'd4:    e.res = ua ^ ub;
                3'd5:    e.res = o.op[3] ? 32'(sa >>> sh) : ua >> sh;
                3'd6:    e.res = ua | ub;
                default: e.res = ua & ub;
            endcase
        end
        return e;
    endfunction

    function automatic op_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic isb, input logic pred, input logic [31:0] pc,
                               input logic [31:0] tgt);
        op_t o;
        o.op = op; o.src1 = a; o.src2 = b; o.isb = isb; o.pred = pred;
        o.pc = pc; o.target = tgt; o.dv = ~isb; o.tag = 4'(a[3:0] ^ b[3:0]);
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.src1 = $urandom;
        o.src2 = ($urandom_range(0, 3) == 0) ? o.src1 : $urandom;
        if ($urandom_range(0, 3) == 0) o.src2 = 32'($urandom_range(0, 40));
        o.pc     = $urandom & 32'hFFFF_FFFC;
        o.target = $urandom & 32'hFFFF_FFFC;
        o.op     = 4'($urandom_range(0, 15));
        o.isb    = ($urandom_range(0, 2) == 0);
        o.pred   = ($urandom_range(0, 1) == 1);
        o.dv     = ($urandom_range(0, 3) != 0);
        o.tag    = 4'($urandom_range(0, 15));
        return o;
    endfunction

    task automatic check1(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // One cycle of stimulus. exp_rdy < 0 skips the in_ready check.
    task automatic drive(input op_t o, input bit v, input bit ordy, input bit fl,
                         input int exp_rdy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; out_ready = ordy; flush = fl;
        in_src1 = o.src1; in_src2 = o.src2; in_pc = o.pc; in_target = o.target;
        in_op = o.op; in_is_branch = o.isb; in_pred = o.pred;
        in_dst_valid = o.dv; in_dst_tag = o.tag;
        #1;
        if (exp_rdy >= 0) check1("in_ready", in_ready, exp_rdy[0]);
        acc = v && in_ready;
        if (fl) begin
            sbq.delete();
            head_seen = 1'b0;
        end
        if (acc) begin
            e = model(o);
            e.acc = cyc;
            e.lat = lat_mode;
            sbq.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
            #1;
            sbq.delete();
            head_seen = 1'b0;
            check1("in_ready_during_rst", in_ready, 1'b0);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({out_valid, out_result, out_mispredict, out_redirect, out_dst_valid, out_dst_tag} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b res=%h misp=%b redir=%h dv=%b tag=%h, required all 0",
                     out_valid, out_result, out_mispredict, out_redirect, out_dst_valid, out_dst_tag);
        end
        rst = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 60) begin
            drive(idle_op, 1'b0, 1'b1, 1'b0, -1, acc);
            n++;
        end
        tests++;
        if (sbq.size() != 0 || out_valid) begin
            fails++;
            $display("FAIL drain: %0d results still pending (out_valid=%b), required 0", sbq.size(), out_valid);
        end
    endtask

    // Monitor: samples after the driver has settled each cycle's inputs.
    exp_t        m_e;
    int          m_lat;
    bit          held = 1'b0;
    logic [70:0] snap, now_v;

    always begin
        @(negedge clk);
        #3;
        now_v = {out_valid, out_result, out_mispredict, out_redirect, out_dst_valid, out_dst_tag};
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                tests++;
                if (now_v !== snap) begin
                    fails++;
                    $display("FAIL stall_hold: got %h, required %h", now_v, snap);
                end
            end
            held = 1'b0;
            if (out_valid && !flush) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious: got out_valid=1 res=%h, required no broadcast", out_result);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        m_lat = cyc - sbq[0].acc;
                        tests++;
                        if (sbq[0].lat ? (m_lat != STAGES) : (m_lat < STAGES)) begin
                            fails++;
                            $display("FAIL latency: got %0d cycles, required %0d", m_lat, STAGES);
                        end
                    end
                    if (out_ready) begin
                        m_e = sbq.pop_front();
                        head_seen = 1'b0;
                        tests++;
                        if (out_result !== m_e.res || out_mispredict !== m_e.misp ||
                            out_redirect !== m_e.redir || out_dst_valid !== m_e.dv ||
                            out_dst_tag !== m_e.tag) begin
                            fails++;
                            $display("FAIL broadcast: got res=%h misp=%b redir=%h dv=%b tag=%h, required res=%h misp=%b redir=%h dv=%b tag=%h",
                                     out_result, out_mispredict, out_redirect, out_dst_valid, out_dst_tag,
                                     m_e.res, m_e.misp, m_e.redir, m_e.dv, m_e.tag);
                        end
                    end else begin
                        held = 1'b1;
                        snap = now_v;
                    end
                end
            end
        end
    end

    initial begin
        bit   acc;
        op_t  dir_ops[7];
        op_t  bp_ops[4];
        bit   ordy_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   idx;

        idle_op = mk(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_reset(3);

        // Directed ALU / branch cases at full throughput.
        lat_mode = 1'b1;
        dir_ops[0] = mk(4'h0, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);            // ADD -> 12
        dir_ops[1] = mk(4'h8, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);            // SUB -> FFFFFFFE
        dir_ops[2] = mk(4'hD, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);    // SRA -> F8000000
        dir_ops[3] = mk(4'h5, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);    // SRL -> 08000000
        dir_ops[4] = mk(4'h2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);    // SLT -> 1
        dir_ops[5] = mk(4'h3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);    // SLTU -> 0
        dir_ops[6] = mk(4'h4, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 32'h100, 32'h200); // BLT mispredict
        foreach (dir_ops[k]) drive(dir_ops[k], 1'b1, 1'b1, 1'b0, 1, acc);
        drain();

        // Random stream, CDB always ready: exact latency, one op per cycle.
        for (int k = 0; k < 80; k++)
            drive(rand_op(), ($urandom_range(0, 3) != 0), 1'b1, 1'b0, 1, acc);
        drain();

        // Random stream with random backpressure.
        lat_mode = 1'b0;
        for (int k = 0; k < 300; k++)
            drive(rand_op(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), 1'b0, -1, acc);
        drain();

        // Four back-to-back ops with the CDB stalled for three cycles.
        foreach (bp_ops[k]) bp_ops[k] = rand_op();
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            drive(bp_ops[idx % 4], (idx < 4), ordy_pat[k], 1'b0, int'(ordy_pat[k]), acc);
            if (acc) idx++;
        end
        tests++;
        if (idx != 4) begin
            fails++;
            $display("FAIL bp_accepted: got %0d ops accepted, required 4", idx);
        end
        drain();

        // Flush with two ops in flight and one offered.
        lat_mode = 1'b1;
        drive(rand_op(), 1'b1, 1'b1, 1'b0, 1, acc);
        drive(rand_op(), 1'b1, 1'b1, 1'b0, 1, acc);
        drive(rand_op(), 1'b1, 1'b0, 1'b1, 0, acc);
        drive(rand_op(), 1'b1, 1'b1, 1'b0, 1, acc);
        check1("flush_clear", out_valid, 1'b0);
        drive(idle_op, 1'b0, 1'b1, 1'b0, -1, acc);
        check1("flush_clear2", out_valid, 1'b0);
        drain();

        // Reset while a result is stalled on the output.
        drive(rand_op(), 1'b1, 1'b1, 1'b0, 1, acc);
        drive(idle_op, 1'b0, 1'b0, 1'b0, -1, acc);
        drive(idle_op, 1'b0, 1'b0, 1'b0, -1, acc);
        check1("pre_reset_valid", out_valid, 1'b1);
        do_reset(1);

        drive(idle_op, 1'b0, 1'b1, 1'b0, 1, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_exec_int_unit
`default_nettype wire

// File: doc/exec_int_unit.md
EXEC_INT_UNIT -- requirements
Module: exec_int_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 4, destination tag width.
REQ-003 SHALL have parameter STAGES, default 1, pipeline depth (legal 1..3).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  kill every in-flight op and any op offered this cycle.
REQ-007 in_valid  input  1  issue slot holds an op.
REQ-008 in_ready  output  1  unit accepts the op this cycle.
REQ-009 in_src1, in_src2  input  XLEN each  operands.
REQ-010 in_pc, in_target  input  XLEN each  op PC and predicted/computed branch target.
REQ-011 in_op  input  4  {alt, funct3}; alt = funct7[5] for ALU ops.
REQ-012 in_is_branch  input  1  op is a conditional branch; funct3 selects the compare.
REQ-013 in_pred  input  1  predicted taken.
REQ-014 in_dst_valid, in_dst_tag  input  1, TAG_W  writes a destination register, and its tag.
REQ-015 out_valid  output  1  result broadcast pending.
REQ-016 out_ready  input  1  CDB accepts the broadcast.
REQ-017 out_result  output  XLEN  ALU result; for branches, in_pc + 4.
REQ-018 out_dst_valid, out_dst_tag  output  1, TAG_W  copied from the issued op.
REQ-019 out_mispredict, out_redirect  output  1, XLEN  branch misprediction flag and the correct next PC.

Function
REQ-020 ALU ops SHALL be: ADD/SUB (funct3 0, alt selects SUB), SLL (1), SLT signed (2), SLTU unsigned (3), XOR (4), SRL/SRA (5, alt selects SRA, arithmetic), OR (6), AND (7).
REQ-021 Shift amount SHALL be in_src2[$clog2(XLEN)-1:0]; all arithmetic is modulo 2^XLEN.
REQ-022 Branch compare SHALL be: BEQ 0, BNE 1, BLT 4, BGE 5, BLTU 6, BGEU 7; funct3 2/3 never taken.
REQ-023 Branch taken SHALL be the compare result.
REQ-024 out_mispredict SHALL be taken XOR in_pred.
REQ-025 out_redirect SHALL be in_target when taken, else in_pc + 4.
REQ-026 For non-branch ops, out_mispredict SHALL be 0 and out_redirect 0.
REQ-027 Pipeline SHALL have STAGES registered slots, each with a valid bit.
REQ-028 Latency from accept to out_valid SHALL be exactly STAGES cycles when out_ready stays high.
REQ-029 advance = out_ready OR NOT out_valid. All slots SHALL shift together on advance and hold otherwise.
REQ-030 in_ready SHALL equal advance AND NOT flush; an op is accepted iff in_valid AND in_ready.
REQ-031 A bubble SHALL fill slot 0 when advance is high and no op is accepted.
REQ-032 Outputs SHALL be held stable while out_valid AND NOT out_ready.
REQ-033 Full pipeline with out_ready high SHALL sustain one accept and one broadcast per cycle.
REQ-034 Flush SHALL clear every slot valid bit on that edge; out_valid is 0 the following cycle.
REQ-035 rst SHALL take priority over flush; flush SHALL take priority over accept.
REQ-036 Ops with in_dst_valid=0 SHALL still produce out_valid, so branches report.

Reset
REQ-037 On rst, all slot valids, out_valid, out_mispredict, out_result, out_redirect, out_dst_tag and out_dst_valid SHALL be 0 on the next edge.
REQ-038 rst mid-operation SHALL discard all in-flight ops; in_ready SHALL be 0 during rst.

Structure
REQ-039 Package exec_pkg SHALL hold the funct3 ALU/branch encoding constants and the alt-bit position.
REQ-040 Combinational datapath SHALL be a sub-module exec_alu_core (result, taken, mispredict, redirect), with exec_int_unit adding the pipeline and handshake around it.

Verification
REQ-041 ADD/SUB: src1=5, src2=7, op=0 -> 12; op=8 -> 0xFFFFFFFE after STAGES cycles.
REQ-042 SRA vs SRL: src1=0x80000000, src2=4 -> SRA 0xF8000000, SRL 0x08000000; SLT(-1,1)=1, SLTU(-1,1)=0.
REQ-043 BLT src1=-2, src2=3, pred=0, pc=0x100, target=0x200 -> mispredict=1, redirect=0x200, result=0x104.
REQ-044 Backpressure: STAGES=2, issue 4 back-to-back ops, out_ready low for 3 cycles -> in_ready low; no op lost or duplicated; order preserved.
REQ-045 Flush with 2 ops in flight plus 1 offered -> none broadcast; first op after flush is broadcast exactly STAGES cycles after accept.
REQ-046 rst asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle and all outputs 0.
